req_encoder: RTL

Registered 4-to-2 request encoder, the inverse of the team's 2-to-4 enable decoder. It latches four request lines into a pending set and selects one pending line. It presents that line's 2-bit index (`out_idx[0]` = a0, `out_idx[1]` = a1) on a valid/ready handshake, then retires the bit once the consumer accepts it. It sits upstream of the decoder, so an accepted `out_idx` can be fed back through the decoder to re-form the one-hot grant.

---
 rtl/req_enc_pkg.sv | 20 ++
 rtl/req_encoder_prio_pick.sv | 28 ++
 rtl/req_encoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/req_enc_pkg.sv
// Shared constants, state type and helpers for the registered 4-to-2 request encoder.
package req_enc_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } req_enc_state_t;

  // One-hot mask for a 2-bit request index; used to retire an accepted grant.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/req_encoder_prio_pick.sv
// Combinational rotating priority picker: returns the first set bit of vec found when
// searching upward from index start, wrapping modulo 4. With start = 0 it degenerates
// to fixed lowest-index priority.
module prio_pick
  import req_enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset down to offset 0 so the nearest hit is written last.
  always_comb begin
    idx = '0;
    pos = '0;
    any = |vec;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = start + IDX_W'(i);
      if (vec[pos]) begin
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Registered 4-to-2 request encoder with valid/ready output handshake.
// Requests are captured into a pending set every cycle; one pending line is selected,
// held on out_idx until accepted, then retired.
// Build option: define REQ_ENCODER_RR_EN for round-robin selection; otherwise the
// lowest pending index always wins.
module req_encoder #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               collide
);

  import req_enc_pkg::*;

  req_enc_state_t     state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               collide_q, collide_d;
  logic [NUM_REQ-1:0] clr_mask;
  logic               accept;
  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

`ifdef REQ_ENCODER_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign pick_start = ptr_q + IDX_W'(1);

  // Pointer remembers the last accepted index so the search resumes just after it.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = idx_q;
    end
  end

  // Round-robin pointer register; reset to 3 so the first search starts at line 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_start = '0;
`endif

  prio_pick u_prio_pick (
    .vec   (pending_q),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign accept   = (state_q == HOLD) && valid_q && out_ready;
  assign clr_mask = accept ? onehot4(idx_q) : '0;

  // Capture and collision detection run every cycle; a set on a retiring bit wins.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | req;
    collide_d = collide_q | (|(req & pending_q & ~clr_mask));
  end

  // Grant FSM: select from the registered pending set only, hold until accepted.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          idx_d   = pick_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, pending set, output registers and sticky collision flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      collide_q <= collide_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pending_q;
  assign collide   = collide_q;

endmodule
